// File: rtl/cic_comp_pkg.sv
// Shared definitions for the CIC droop-compensation FIR: default widths,
// MAC FSM states, the symmetric compensation taps and the round/saturate helper.
package cic_comp_pkg;

  localparam int DEF_IN_WIDTH   = 26;
  localparam int DEF_OUT_WIDTH  = 26;
  localparam int DEF_COEF_WIDTH = 16;
  localparam int DEF_NTAPS      = 32;
  localparam int DEF_SHIFT      = 15;
  localparam int RW             = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Q1.15 inverse-sinc taps for a CIC5/R64 stage, DC gain of one (sum = 32768).
  localparam logic [DEF_NTAPS-1:0][DEF_COEF_WIDTH-1:0] COEFS = {
    -16'sd8,    16'sd14,   16'sd28,   -16'sd22,  -16'sd62,   16'sd26,   16'sd118,  -16'sd14,
    -16'sd206, -16'sd36,   16'sd332,   16'sd146, -16'sd536, -16'sd420,  16'sd960,   16'sd16064,
     16'sd16064, 16'sd960, -16'sd420, -16'sd536,  16'sd146,  16'sd332, -16'sd36,  -16'sd206,
    -16'sd14,   16'sd118,  16'sd26,   -16'sd62,  -16'sd22,   16'sd28,   16'sd14,   -16'sd8
  };

  // Round half up at bit (shift-1), arithmetic shift, then clamp to out_w signed bits.
  function automatic logic signed [RW-1:0] sat_round(
    input logic signed [RW-1:0] acc,
    input int                   shift,
    input int                   out_w
  );
    logic signed [RW-1:0] w_half;
    logic signed [RW-1:0] w_r;
    logic signed [RW-1:0] w_hi;
    logic signed [RW-1:0] w_lo;
    w_half = 64'sd1 <<< (shift - 1);
    w_r    = (acc + w_half) >>> shift;
    w_hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    w_lo   = -(64'sd1 <<< (out_w - 1));
    if (w_r > w_hi) begin
      sat_round = w_hi;
    end else if (w_r < w_lo) begin
      sat_round = w_lo;
    end else begin
      sat_round = w_r;
    end
  endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Single multiplier-accumulator for the compensation FIR: registered operand
// fetch, full-precision accumulate, and a registered round/saturate stage.
module cic_comp_mac import cic_comp_pkg::*; #(
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int ACC_WIDTH  = DEF_IN_WIDTH + DEF_COEF_WIDTH + $clog2(DEF_NTAPS),
  parameter int SHIFT      = DEF_SHIFT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_rd_en,
  input  logic                         i_first,
  input  logic signed [IN_WIDTH-1:0]   i_sample,
  input  logic signed [COEF_WIDTH-1:0] i_coef,
  input  logic                         i_round_en,
  output logic signed [OUT_WIDTH-1:0]  o_round
);

  localparam int PW = IN_WIDTH + COEF_WIDTH;

  logic signed [IN_WIDTH-1:0]   r_x;
  logic signed [COEF_WIDTH-1:0] r_c;
  logic                         r_vld;
  logic                         r_first;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [OUT_WIDTH-1:0]  r_round;
  logic signed [PW-1:0]         w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic signed [RW-1:0]         w_acc_ext;

  assign w_prod     = PW'(r_x) * PW'(r_c);
  assign w_prod_ext = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};
  assign w_acc_ext  = {{(RW-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc};
  assign o_round    = r_round;

  // Operand pipeline register: buffer word and coefficient for the current tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_c     <= '0;
      r_vld   <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_x     <= i_sample;
      r_c     <= i_coef;
      r_vld   <= i_rd_en;
      r_first <= i_first;
    end
  end

  // Accumulator; tap 0 loads so no separate clear cycle is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (r_vld) begin
      r_acc <= r_first ? w_prod_ext : r_acc + w_prod_ext;
    end
  end

  // Round/saturate result register, loaded once the last product has landed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round <= '0;
    end else if (i_round_en) begin
      r_round <= OUT_WIDTH'(sat_round(w_acc_ext, SHIFT, OUT_WIDTH));
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// Decimate-by-2 CIC droop-compensation FIR: sample ring buffer, write pointer,
// decimation phase and the MAC sequencing FSM around cic_comp_mac.
module cic_comp_fir import cic_comp_pkg::*; #(
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int NTAPS      = DEF_NTAPS,
  parameter int SHIFT      = DEF_SHIFT,
  parameter int ACC_WIDTH  = IN_WIDTH + COEF_WIDTH + $clog2(NTAPS),
  parameter logic [NTAPS-1:0][COEF_WIDTH-1:0] P_COEFS = COEFS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        ce_in,
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int AW = $clog2(NTAPS);
  localparam int CW = 7;
  localparam logic [CW-1:0] CNT_NTAPS = CW'(NTAPS);
  localparam logic [CW-1:0] CNT_RND   = CW'(NTAPS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(NTAPS + 2);

  logic signed [IN_WIDTH-1:0]  r_buf [NTAPS];
  logic [AW-1:0]               r_wp;
  logic [AW-1:0]               r_base;
  logic                        r_phase;
  logic [CW-1:0]               r_cnt;
  state_t                      r_state;
  logic signed [OUT_WIDTH-1:0] r_dout;
  logic                        r_out_valid;
  logic                        r_busy;
  logic                        r_overrun;

  logic                        w_wr;
  logic                        w_trig;
  logic [AW-1:0]               w_k;
  logic [AW-1:0]               w_addr;
  logic                        w_rd_en;
  logic                        w_first;
  logic                        w_round_en;
  logic signed [OUT_WIDTH-1:0] w_round;

  assign w_wr       = en & ce_in;
  assign w_trig     = w_wr & r_phase;
  assign w_k        = r_cnt[AW-1:0];
  assign w_addr     = r_base - w_k;
  assign w_rd_en    = (r_state == MAC) && (r_cnt < CNT_NTAPS);
  assign w_first    = (r_cnt == {CW{1'b0}});
  assign w_round_en = (r_state == ROUND) && (r_cnt == CNT_RND);

  assign dout      = r_dout;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

  // Sample ring buffer, write pointer and decimation phase; writes run in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_buf[i] <= '0;
      end
      r_wp    <= '0;
      r_phase <= 1'b0;
    end else if (w_wr) begin
      r_buf[r_wp] <= din;
      r_wp        <= r_wp + AW'(1'b1);
      r_phase     <= ~r_phase;
    end
  end

  // MAC sequencer: NTAPS reads, one drain cycle, round, then publish in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_base      <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_trig && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_base  <= r_wp;
            r_cnt   <= '0;
            r_state <= MAC;
            r_busy  <= 1'b1;
          end
        end
        MAC: begin
          r_cnt <= r_cnt + CW'(1'b1);
          if (r_cnt == CNT_NTAPS) begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_cnt <= r_cnt + CW'(1'b1);
          if (r_cnt == CNT_LAST) begin
            r_state     <= DONE;
            r_dout      <= w_round;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  cic_comp_mac #(
    .IN_WIDTH   (IN_WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SHIFT      (SHIFT)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .i_rd_en    (w_rd_en),
    .i_first    (w_first),
    .i_sample   (r_buf[w_addr]),
    .i_coef     ($signed(P_COEFS[w_k])),
    .i_round_en (w_round_en),
    .o_round    (w_round)
  );

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: three instances (ramp, 1024 and 2048 taps)
// share one stimulus stream; expected words come from a direct convolution model.
module tb_cic_comp_fir;

  localparam int NT  = 32;
  localparam int NI  = 3;
  localparam int LAT = NT + 3;
  localparam longint OMAX = 33554431;
  localparam longint OMIN = -33554432;

  typedef struct {
    longint val;
    longint cyc;
  } exp_t;

  function automatic int coef_rule(input int mode, input int k);
    case (mode)
      0:       return k + 1;
      1:       return 1024;
      default: return 2048;
    endcase
  endfunction

  function automatic logic [NT-1:0][15:0] mk_coefs(input int mode);
    logic [NT-1:0][15:0] v;
    for (int k = 0; k < NT; k++) v[k] = 16'(coef_rule(mode, k));
    return v;
  endfunction

  logic clk = 1'b0;
  logic rst, en, ce_in;
  logic signed [25:0] din;
  logic signed [25:0] dout [NI];
  logic out_valid [NI];
  logic busy [NI];
  logic overrun [NI];

  longint cyc = 0;
  int checks = 0;
  int failures = 0;

  longint hist[$];
  bit     m_phase;
  bit     m_ovr;
  bit     any_acc;
  longint last_acc;
  exp_t   exp_q [NI][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    exp_t em;

    cic_comp_fir #(.P_COEFS(mk_coefs(g))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .ce_in     (ce_in),
      .din       (din),
      .dout      (dout[g]),
      .out_valid (out_valid[g]),
      .busy      (busy[g]),
      .overrun   (overrun[g])
    );

    always @(negedge clk) begin
      if (out_valid[g] === 1'b1) begin
        checks++;
        if (exp_q[g].size() == 0) begin
          failures++;
          $display("FAIL unexpected_out inst=%0d got dout=%0d at cycle %0d, required no out_valid", g, dout[g], cyc);
        end else begin
          em = exp_q[g].pop_front();
          if (longint'(dout[g]) != em.val || cyc != em.cyc + LAT || busy[g] !== 1'b1) begin
            failures++;
            $display("FAIL out_word inst=%0d got dout=%0d cycle=%0d busy=%0b, required dout=%0d cycle=%0d busy=1",
                     g, dout[g], cyc, busy[g], em.val, em.cyc + LAT);
          end
        end
      end
    end
  end

  function automatic longint model_out(input int inst, input int n);
    longint y = 0;
    longint r;
    for (int k = 0; k < NT; k++) begin
      if (n - k >= 0) y += hist[n - k] * longint'(coef_rule(inst, k));
    end
    r = (y + 64'sd16384) >>> 15;
    if (r > OMAX) r = OMAX;
    else if (r < OMIN) r = OMIN;
    return r;
  endfunction

  task automatic put(input longint x, input bit e, input int gap);
    longint t;
    exp_t ex;
    bit exp_busy;
    en = e; ce_in = 1'b1; din = 26'(x);
    t = cyc + 1;
    if (e) begin
      hist.push_back(x);
      if (m_phase) begin
        if (!any_acc || (t - last_acc) >= NT + 5) begin
          for (int i = 0; i < NI; i++) begin
            ex.val = model_out(i, hist.size() - 1);
            ex.cyc = t;
            exp_q[i].push_back(ex);
          end
          any_acc = 1'b1; last_acc = t;
        end else begin
          m_ovr = 1'b1;
        end
      end
      m_phase = ~m_phase;
    end
    @(negedge clk);
    ce_in = 1'b0; din = 26'($urandom);
    exp_busy = any_acc && ((cyc - last_acc) <= NT + 3);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (overrun[i] !== m_ovr || busy[i] !== exp_busy) begin
        failures++;
        $display("FAIL flags inst=%0d cycle=%0d got overrun=%0b busy=%0b, required overrun=%0b busy=%0b",
                 i, cyc, overrun[i], busy[i], m_ovr, exp_busy);
      end
    end
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ce_in = 1'b0; en = 1'b1;
    hist.delete(); m_phase = 1'b0; m_ovr = 1'b0; any_acc = 1'b0; last_acc = 0;
    for (int i = 0; i < NI; i++) exp_q[i].delete();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (dout[i] !== 26'sd0 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || overrun[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state inst=%0d got dout=%0d ov=%0b busy=%0b overrun=%0b, required all 0",
                 i, dout[i], out_valid[i], busy[i], overrun[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ce_in = 1'b0; din = 26'sd0;
    @(negedge clk);
    do_reset();

    // Impulse on sample #1: ramp taps give 1,3,...,31 then 0.
    for (int s = 0; s < 34; s++) put((s == 1) ? 64'sd32768 : 64'sd0, 1'b1, 64);

    // DC level across many pointer wraps.
    for (int s = 0; s < 200; s++) put(64'sd1000, 1'b1, 64);

    // Full-scale positive then negative: saturation on the 2048-tap instance.
    for (int s = 0; s < 40; s++) put(64'sd33554431, 1'b1, 64);
    for (int s = 0; s < 40; s++) put(-64'sd33554432, 1'b1, 64);

    // Random full-range samples with random spacing.
    for (int s = 0; s < 40; s++) put(longint'($signed(26'($urandom))), 1'b1, int'($urandom_range(40, 90)));

    // en low across strobes while a computation is in flight.
    if (!m_phase) put(longint'($signed(26'($urandom))), 1'b1, 64);
    put(longint'($signed(26'($urandom))), 1'b1, 4);
    for (int s = 0; s < 10; s++) put(longint'($signed(26'($urandom))), 1'b0, 8);
    for (int s = 0; s < 6; s++) put(longint'($signed(26'($urandom))), 1'b1, 64);

    // Overrun: strobes every 8 clocks from a cleared buffer.
    do_reset();
    put(longint'($signed(26'($urandom))), 1'b1, 8);
    put(longint'($signed(26'($urandom))), 1'b1, 8);
    for (int s = 0; s < 8; s++) put(64'sd0, 1'b1, 8);
    repeat (80) @(negedge clk);

    // Reset 10 cycles after a trigger, then a clean run from an empty buffer.
    do_reset();
    put(longint'($signed(26'($urandom))), 1'b1, 64);
    put(longint'($signed(26'($urandom))), 1'b1, 11);
    do_reset();
    for (int s = 0; s < 6; s++) put(longint'($signed(26'($urandom))), 1'b1, 64);

    repeat (100) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        failures++;
        $display("FAIL drain inst=%0d got %0d outstanding results, required 0", i, exp_q[i].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
